// File: rtl/demux_pkg.sv
// Shared constants and helpers for the lane-steering blocks.
// Lane k of a packed lane bus sits at bit offset lane_slice(k, w).
package demux_pkg;

   localparam int NUM_LANES = 16;
   localparam int SEL_W     = 4;

   function automatic int lane_slice(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/onehot_dec4to16.sv
// 4-to-16 one-hot select decoder, purely combinational.
// Shared by the steering blocks that fan one source out to 16 lanes.
module onehot_dec4to16
   import demux_pkg::*;
(
   input  logic [SEL_W-1:0]     sel,
   output logic [NUM_LANES-1:0] onehot
);

   always_comb begin
      onehot      = '0;
      onehot[sel] = 1'b1;
   end

endmodule

// File: rtl/demux_1to16.sv
// 1-to-16 demultiplexer: steers in onto lane sel, all other lanes zero.
// REG_OUT selects a 1-cycle registered output or a pure combinational path.
module demux_1to16
   import demux_pkg::*;
#(
   parameter int DATA_W  = 1,
   parameter bit REG_OUT = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DATA_W-1:0]           in,
   input  logic [SEL_W-1:0]            sel,
   output logic [NUM_LANES*DATA_W-1:0] out
);

   logic [NUM_LANES-1:0]        onehot;
   logic [NUM_LANES*DATA_W-1:0] lanes;

   onehot_dec4to16 u_dec (
      .sel    (sel),
      .onehot (onehot)
   );

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      assign lanes[lane_slice(k, DATA_W) +: DATA_W] =
         in & {DATA_W{onehot[k]}};
   end

   if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) out <= '0;
         else        out <= lanes;
      end
   end else begin : g_comb
      // Clock and reset are intentionally ignored on this path.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out = lanes;
   end

endmodule

// File: tb/tb_demux_1to16.sv
// Directed bench for demux_1to16: registered 1-bit and combinational 8-bit variants.
// Expected lane patterns are hand-computed per vector.
module tb_demux_1to16;

   logic         clk;
   logic         rst_n;
   logic [0:0]   in1;
   logic [3:0]   sel1;
   logic [15:0]  out1;
   logic [7:0]   in8;
   logic [3:0]   sel8;
   logic [127:0] out8;

   int errs;
   int checks;

   demux_1to16 #(.DATA_W(1), .REG_OUT(1'b1)) dut_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in1),
      .sel   (sel1),
      .out   (out1)
   );

   demux_1to16 #(.DATA_W(8), .REG_OUT(1'b0)) dut_comb (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in8),
      .sel   (sel8),
      .out   (out8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      errs   = 0;
      checks = 0;
      rst_n  = 1'b0;
      in1    = 1'b1;
      sel1   = 4'd5;
      in8    = 8'h00;
      sel8   = 4'd0;

      #1;
      chk("reset_t0", {112'd0, out1}, 128'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_hold", {112'd0, out1}, 128'h0);
      end

      rst_n = 1'b1;
      tick();
      chk("reset_release", {112'd0, out1}, 128'h0020);

      // One-hot sweep with in = 1
      for (int i = 0; i < 16; i++) begin
         sel1 = 4'(i);
         tick();
         chk("sweep", {112'd0, out1}, 128'h1 << i);
         chk("sweep_onebit", 128'($countones(out1)), 128'd1);
      end

      in1 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         sel1 = 4'(i);
         tick();
         chk("zero_data", {112'd0, out1}, 128'h0);
      end

      // sel glitches between edges must not reach out
      in1  = 1'b1;
      sel1 = 4'd2;
      tick();
      chk("glitch_base", {112'd0, out1}, 128'h0004);
      #1 sel1 = 4'd9;
      #1 chk("glitch_mid", {112'd0, out1}, 128'h0004);
      #1 sel1 = 4'd2;
      tick();
      chk("glitch_after", {112'd0, out1}, 128'h0004);

      // Mid-stream async reset, plus comb path ignoring reset
      sel1 = 4'd15;
      in8  = 8'h3C;
      sel8 = 4'd7;
      tick();
      chk("pre_areset", {112'd0, out1}, 128'h8000);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {112'd0, out1}, 128'h0);
      chk("comb_in_reset", out8, 128'h3C << 56);
      tick();
      chk("async_reset_hold", {112'd0, out1}, 128'h0);
      #1 rst_n = 1'b1;
      tick();
      chk("post_areset", {112'd0, out1}, 128'h8000);

      // Combinational 8-bit variant
      in8  = 8'hA5;
      sel8 = 4'd3;
      #1 chk("comb_sel3", out8, 128'hA500_0000);
      sel8 = 4'd0;
      #1 chk("comb_sel0", out8, 128'h0000_00A5);
      sel8 = 4'd15;
      #1 chk("comb_sel15", out8, {8'hA5, 120'd0});
      in8 = 8'h00;
      #1 chk("comb_zero", out8, 128'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
